// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage with redirect priority, stall hold and alignment check
module pc_sequencer #(
    parameter int               NBits        = 32,
    parameter logic [NBits-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [NBits-1:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Stall,
    input  logic [NBits-1:0] in_PcPlus4,
    input  logic             in_BranchTaken,
    input  logic [NBits-1:0] in_BranchTarget,
    input  logic             in_Jump,
    input  logic [NBits-1:0] in_JumpTarget,
    input  logic             in_JumpReg,
    input  logic [NBits-1:0] in_RegTarget,
    input  logic             in_Exception,
    output logic [NBits-1:0] out_PC,
    output logic             out_Valid,
    output logic             out_Misaligned,
    output logic [NBits-1:0] out_BadAddr
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t           state, state_next;
    logic [NBits-1:0] pc, pc_next;
    logic             mis, mis_next;
    logic [NBits-1:0] bad, bad_next;
    logic [NBits-1:0] pend_pc, pend_pc_next;
    logic             pend_mis, pend_mis_next;
    logic [NBits-1:0] pend_bad, pend_bad_next;
    logic             pend_exc, pend_exc_next;

    logic             redirect;
    logic             has_raw;
    logic [NBits-1:0] raw_target;
    logic [NBits-1:0] sel_target;
    logic             sel_mis;

    assign redirect = in_Exception | in_JumpReg | in_Jump | in_BranchTaken;

    // Pick this cycle's target by priority; checked targets that are misaligned become the exception vector
    always_comb begin
        has_raw    = 1'b0;
        raw_target = '0;
        sel_target = in_PcPlus4;
        sel_mis    = 1'b0;
        if (in_Exception) begin
            sel_target = EXC_VECTOR;
        end else if (in_JumpReg) begin
            has_raw    = 1'b1;
            raw_target = in_RegTarget;
        end else if (in_Jump) begin
            has_raw    = 1'b1;
            raw_target = in_JumpTarget;
        end else if (in_BranchTaken) begin
            has_raw    = 1'b1;
            raw_target = in_BranchTarget;
        end
        if (has_raw) begin
            if (raw_target[1:0] != 2'b00) begin
                sel_target = EXC_VECTOR;
                sel_mis    = 1'b1;
            end else begin
                sel_target = raw_target;
            end
        end
    end

    // Next-state and next-datapath decisions; misaligned pulse only fires when the PC is actually loaded
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        mis_next      = 1'b0;
        bad_next      = bad;
        pend_pc_next  = pend_pc;
        pend_mis_next = pend_mis;
        pend_bad_next = pend_bad;
        pend_exc_next = pend_exc;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (!in_Stall) begin
                    pc_next  = sel_target;
                    mis_next = sel_mis;
                    if (sel_mis) bad_next = raw_target;
                end else if (redirect) begin
                    pend_pc_next  = sel_target;
                    pend_mis_next = sel_mis;
                    pend_bad_next = raw_target;
                    pend_exc_next = in_Exception;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (in_Stall) begin
                    // A held exception is only displaced by another exception
                    if (redirect && !(pend_exc && !in_Exception)) begin
                        pend_pc_next  = sel_target;
                        pend_mis_next = sel_mis;
                        pend_bad_next = raw_target;
                        pend_exc_next = in_Exception;
                    end
                end else begin
                    state_next    = RUN;
                    pend_exc_next = 1'b0;
                    if (in_Exception) begin
                        pc_next = EXC_VECTOR;
                    end else begin
                        pc_next  = pend_pc;
                        mis_next = pend_mis;
                        if (pend_mis) bad_next = pend_bad;
                    end
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            mis      <= 1'b0;
            bad      <= '0;
            pend_pc  <= '0;
            pend_mis <= 1'b0;
            pend_bad <= '0;
            pend_exc <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            mis      <= mis_next;
            bad      <= bad_next;
            pend_pc  <= pend_pc_next;
            pend_mis <= pend_mis_next;
            pend_bad <= pend_bad_next;
            pend_exc <= pend_exc_next;
        end
    end

    assign out_PC         = pc;
    assign out_Valid      = (state != BOOT);
    assign out_Misaligned = mis;
    assign out_BadAddr    = bad;

endmodule
